// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC, instruction-memory request handshake and IF/ID register.
// Optional performance counters are enabled with the IF_PERF_CNT_EN macro.
//
//  state | meaning
//  REQ   | imem_req=1, imem_addr=pc; fetching the current PC
//  KILL  | imem_req=1, imem_addr=old pc; stale fetch in flight, redirect pending
//  HOLD  | imem_req=0; fetched word parked in the 1-entry buffer during stall
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_KILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pend_pc;
    logic [31:0] pend_pc_nxt;
    logic [31:0] buf_pc;
    logic [31:0] buf_pc_nxt;
    logic [31:0] buf_inst;
    logic [31:0] buf_inst_nxt;
    logic [31:0] id_pc_nxt;
    logic [31:0] id_inst_nxt;
    logic        id_valid_nxt;
    logic [31:0] redirect_al;

    assign redirect_al = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ: begin
                if (imem_ready) begin
                    if (!flush && stall) begin
                        state_nxt = ST_HOLD;
                    end
                end else if (flush) begin
                    state_nxt = ST_KILL;
                end
            end
            ST_KILL: begin
                if (imem_ready) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (flush || !stall) begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_REQ;
        endcase
    end

    // Request is dropped combinationally during reset so the memory side sees
    // the abandoned handshake in the same cycle.
    always_comb begin
        imem_req     = !rst && (state != ST_HOLD);
        imem_addr    = pc;
        pc_nxt       = pc;
        pend_pc_nxt  = pend_pc;
        buf_pc_nxt   = buf_pc;
        buf_inst_nxt = buf_inst;
        id_pc_nxt    = if_id_pc;
        id_inst_nxt  = if_id_inst;
        id_valid_nxt = if_id_valid;
        case (state)
            ST_REQ, ST_KILL: begin
                if (flush) begin
                    id_inst_nxt  = NOP_INST;
                    id_valid_nxt = 1'b0;
                    if (imem_ready) begin
                        pc_nxt = redirect_al;
                    end else begin
                        pend_pc_nxt = redirect_al;
                    end
                end else if (state == ST_KILL) begin
                    if (!stall) begin
                        id_inst_nxt  = NOP_INST;
                        id_valid_nxt = 1'b0;
                    end
                    if (imem_ready) begin
                        pc_nxt = pend_pc;
                    end
                end else if (stall) begin
                    if (imem_ready) begin
                        buf_pc_nxt   = pc;
                        buf_inst_nxt = imem_rdata;
                    end
                end else if (imem_ready) begin
                    id_pc_nxt    = pc;
                    id_inst_nxt  = imem_rdata;
                    id_valid_nxt = 1'b1;
                    pc_nxt       = pc + 32'd4;
                end else begin
                    id_inst_nxt  = NOP_INST;
                    id_valid_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    id_inst_nxt  = NOP_INST;
                    id_valid_nxt = 1'b0;
                    pc_nxt       = redirect_al;
                end else if (!stall) begin
                    id_pc_nxt    = buf_pc;
                    id_inst_nxt  = buf_inst;
                    id_valid_nxt = 1'b1;
                    pc_nxt       = pc + 32'd4;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            pend_pc     <= RESET_PC;
            buf_pc      <= 32'd0;
            buf_inst    <= NOP_INST;
            if_id_pc    <= 32'd0;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            pend_pc     <= pend_pc_nxt;
            buf_pc      <= buf_pc_nxt;
            buf_inst    <= buf_inst_nxt;
            if_id_pc    <= id_pc_nxt;
            if_id_inst  <= id_inst_nxt;
            if_id_valid <= id_valid_nxt;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flush_count  <= 32'd0;
        end else begin
            if (stall && !flush) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
